// File: rtl/banked_regfile.sv
// banked_regfile: dual-bank (int/fp) register file with two combinational
// read ports, a single-cycle write port with cross-bank moves, a long-latency
// writeback port and a per-register pending scoreboard.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   rd_fp, rs, rt       read bank select and read addresses A/B
//   busA, busB          combinational read data (bypassed)
//   we, wr_mode, wa,    single-cycle write; wr_mode selects int/fp source and
//   busW                destination (0 int<=busW, 1 fp<=int[rs],
//                       2 int<=fp[rs], 3 fp<=busW)
//   issue_*             marks a destination register pending
//   wb_*                long-latency writeback, clears pending
//   stall_a/b/w         combinational pending status for the read/write targets
//   collision_err       sticky flag: we and wb hit the same register
module banked_regfile #(
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  DEPTH    = 32,
  parameter bit           ZERO_REG = 1'b1,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_fp,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  output logic [WIDTH-1:0] busA,
  output logic [WIDTH-1:0] busB,
  input  logic             we,
  input  logic [1:0]       wr_mode,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] busW,
  input  logic             issue_valid,
  input  logic             issue_fp,
  input  logic [AW-1:0]    issue_addr,
  input  logic             wb_valid,
  input  logic             wb_fp,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall_a,
  output logic             stall_b,
  output logic             stall_w,
  output logic             collision_err
);

  logic [WIDTH-1:0] int_q [DEPTH];
  logic [WIDTH-1:0] fp_q  [DEPTH];
  logic [DEPTH-1:0] pend_int_q;
  logic [DEPTH-1:0] pend_fp_q;
  logic [DEPTH-1:0] pend_int_d;
  logic [DEPTH-1:0] pend_fp_d;

  logic             w_dst_fp;
  logic             w_src_fp;
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] w_val;
  logic             same_reg;
  logic             we_keep;
  logic             wb_keep;
  logic             issue_keep;

  // True for the hardwired integer zero register.
  function automatic logic is_zero(input logic fp, input logic [AW-1:0] a);
    return ZERO_REG && !fp && (a == '0);
  endfunction

  // Single-cycle write path: destination bank, move source and final value.
  // The move source sees only the writeback bypass, never the write itself.
  always_comb begin
    w_dst_fp = wr_mode[0];
    w_src_fp = wr_mode[1];
    src_val  = w_src_fp ? fp_q[rs] : int_q[rs];
    if (wb_valid && (wb_fp == w_src_fp) && (wb_addr == rs)) src_val = wb_data;
    if (is_zero(w_src_fp, rs)) src_val = '0;
    w_val = ((wr_mode == 2'd1) || (wr_mode == 2'd2)) ? src_val : busW;
  end

  // Qualified write/writeback/issue strobes; wb wins a same-register race.
  always_comb begin
    same_reg   = we && wb_valid && (wb_fp == w_dst_fp) && (wb_addr == wa);
    we_keep    = we && !same_reg && !is_zero(w_dst_fp, wa);
    wb_keep    = wb_valid && !is_zero(wb_fp, wb_addr);
    issue_keep = issue_valid && !is_zero(issue_fp, issue_addr);
  end

  // Read port A: zero register > wb bypass > write bypass > array.
  always_comb begin
    busA = rd_fp ? fp_q[rs] : int_q[rs];
    if (we_keep && (w_dst_fp == rd_fp) && (wa == rs)) busA = w_val;
    if (wb_keep && (wb_fp == rd_fp) && (wb_addr == rs)) busA = wb_data;
    if (is_zero(rd_fp, rs)) busA = '0;
  end

  // Read port B: same priority as port A.
  always_comb begin
    busB = rd_fp ? fp_q[rt] : int_q[rt];
    if (we_keep && (w_dst_fp == rd_fp) && (wa == rt)) busB = w_val;
    if (wb_keep && (wb_fp == rd_fp) && (wb_addr == rt)) busB = wb_data;
    if (is_zero(rd_fp, rt)) busB = '0;
  end

  // Scoreboard next state: a same-cycle issue overrides the writeback clear.
  always_comb begin
    pend_int_d = pend_int_q;
    pend_fp_d  = pend_fp_q;
    if (wb_keep) begin
      if (wb_fp) pend_fp_d[wb_addr] = 1'b0;
      else       pend_int_d[wb_addr] = 1'b0;
    end
    if (issue_keep) begin
      if (issue_fp) pend_fp_d[issue_addr] = 1'b1;
      else          pend_int_d[issue_addr] = 1'b1;
    end
  end

  // Stalls reflect the registered pending state only.
  always_comb begin
    stall_a = rd_fp ? pend_fp_q[rs] : pend_int_q[rs];
    stall_b = rd_fp ? pend_fp_q[rt] : pend_int_q[rt];
    stall_w = we && (w_dst_fp ? pend_fp_q[wa] : pend_int_q[wa]);
  end

  // Register arrays, scoreboard and sticky collision flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        int_q[i] <= '0;
        fp_q[i]  <= '0;
      end
      pend_int_q    <= '0;
      pend_fp_q     <= '0;
      collision_err <= 1'b0;
    end else begin
      if (we_keep) begin
        if (w_dst_fp) fp_q[wa]  <= w_val;
        else          int_q[wa] <= w_val;
      end
      if (wb_keep) begin
        if (wb_fp) fp_q[wb_addr]  <= wb_data;
        else       int_q[wb_addr] <= wb_data;
      end
      pend_int_q <= pend_int_d;
      pend_fp_q  <= pend_fp_d;
      if (same_reg) collision_err <= 1'b1;
    end
  end

endmodule
